button_event_arbiter: RTL

- Shares one downstream command consumer between N conditioned push-button channels (each a debounce → synchronise → edge-detect chain emitting one-cycle pulses).
- Latches each button pulse as a pending request and grants requests round-robin.
- Presents the granted channel on a valid/ready command interface.
- Generates the periodic sample tick that paces the debouncers, so all channels sample coherently.

---
 rtl/button_event_arbiter_pkg.sv | 26 ++
 rtl/button_event_arbiter_rr_select.sv | 33 +++
 rtl/button_event_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/button_event_arbiter_pkg.sv
// Shared types and constants for the button event arbiter and its
// round-robin selector.
package button_event_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  // Sample-tick divider for the board clock (1 ms at 100 MHz).
  localparam int DEFAULT_TICK_DIV = 100000;

  // Ceiling log2, never below 1 so single-bit fields stay legal.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/button_event_arbiter_rr_select.sv
// Combinational round-robin pick: first set request after last_grant,
// wrapping modulo N.
module button_event_arbiter_rr_select
  import button_event_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_grant,
  output logic [ID_W-1:0] sel,
  output logic            any_req
);

  int   idx;
  logic found;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last_grant) + off) % N;
      if (!found && req[idx[ID_W-1:0]]) begin
        sel   = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/button_event_arbiter.sv
// Shares one command consumer between N push-button channels: latches
// press pulses as pending requests, grants them round-robin, paces debouncers.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_IDLE  | nothing offered; load the next pending channel if any
//   ST_OFFER | cmd_id offered with cmd_valid=1 until handshake
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter  int N_BTN    = 4,
  parameter  int TICK_DIV = DEFAULT_TICK_DIV,
  parameter  int DROP_W   = 8,
  localparam int ID_W     = clog2(N_BTN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  btn_pulse,
  output logic              sample_tick,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ID_W-1:0]   cmd_id,
  output logic [N_BTN-1:0]  pending,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int CNT_W = clog2(TICK_DIV);

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  sel_id;
  logic             any_req;
  logic             load;
  logic [N_BTN-1:0] clear_mask;
  logic             drop_now;

  // The tick is registered one count early so it lines up with tick_cnt == TICK_DIV-1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt    <= '0;
      sample_tick <= 1'b0;
    end else begin
      tick_cnt    <= (tick_cnt == CNT_W'(TICK_DIV - 1)) ? '0 : tick_cnt + CNT_W'(1);
      sample_tick <= (tick_cnt == CNT_W'(TICK_DIV - 2));
    end
  end

  button_event_arbiter_rr_select #(
    .N    (N_BTN),
    .ID_W (ID_W)
  ) u_rr_select (
    .req        (pending),
    .last_grant (last_grant),
    .sel        (sel_id),
    .any_req    (any_req)
  );

  assign load       = any_req && ((state == ST_IDLE) || cmd_ready);
  assign clear_mask = load ? (N_BTN'(1) << sel_id) : '0;
  assign drop_now   = |(btn_pulse & pending & ~clear_mask);

  // A pulse on the channel being loaded re-arms it rather than counting as a drop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      pending <= (pending & ~clear_mask) | btn_pulse;
      if (drop_now && (drop_cnt != {DROP_W{1'b1}}))
        drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cmd_valid  <= 1'b0;
      cmd_id     <= '0;
      last_grant <= ID_W'(N_BTN - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            cmd_id     <= sel_id;
            last_grant <= sel_id;
            cmd_valid  <= 1'b1;
            state      <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (cmd_ready) begin
            if (any_req) begin
              cmd_id     <= sel_id;
              last_grant <= sel_id;
            end else begin
              cmd_valid <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end
        default: begin
          cmd_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
